// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM arbiter and its posted-write buffer.
package vram_pkg;

    localparam int unsigned VRAM_AW     = 15;
    localparam int unsigned VRAM_DW     = 8;
    // Video read latency: address cycle, RAM output cycle, then registered vid_data.
    localparam int unsigned VID_LATENCY = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StRdcap = 2'd2,
        StAck   = 2'd3
    } vram_arb_state_t;

endpackage

// File: rtl/vram_wbuf.sv
// One-entry posted-write buffer for the VRAM arbiter; only built with VRAM_POSTED_WRITE_EN.
// It drains into RAM on the first cycle the video fetcher leaves the port free.
`ifdef VRAM_POSTED_WRITE_EN
module vram_wbuf
    import vram_pkg::*;
(
    input  logic               pixel_clock,
    input  logic               reset,
    input  logic               push,
    input  logic [VRAM_AW-1:0] push_addr,
    input  logic [VRAM_DW-1:0] push_data,
    input  logic               vid_busy,
    output logic               full,
    output logic               drain,
    output logic [VRAM_AW-1:0] drain_addr,
    output logic [VRAM_DW-1:0] drain_data
);

    logic               valid_q;
    logic [VRAM_AW-1:0] addr_q;
    logic [VRAM_DW-1:0] data_q;

    assign full       = valid_q;
    assign drain      = valid_q && !vid_busy;
    assign drain_addr = addr_q;
    assign drain_data = data_q;

    // The arbiter only pushes while empty, so push and drain never coincide.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (push) begin
            valid_q <= 1'b1;
            addr_q  <= push_addr;
            data_q  <= push_data;
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches always win, the CPU uses the free cycles.
// Define VRAM_POSTED_WRITE_EN to add a one-entry posted-write buffer (vram_wbuf).
module vram_arbiter
    import vram_pkg::*;
(
    input  logic               pixel_clock,
    input  logic               reset,
    input  logic               vid_rd,
    input  logic [VRAM_AW-1:0] vid_addr,
    output logic [VRAM_DW-1:0] vid_data,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [VRAM_AW-1:0] cpu_addr,
    input  logic [VRAM_DW-1:0] cpu_wdata,
    output logic [VRAM_DW-1:0] cpu_rdata,
    output logic               cpu_ack,
    output logic               cpu_wait,
    output logic [VRAM_AW-1:0] mem_addr,
    output logic               mem_we,
    output logic [VRAM_DW-1:0] mem_wdata,
    input  logic [VRAM_DW-1:0] mem_rdata
);

    vram_arb_state_t    state_q, state_d;
    logic               req_q;
    logic               ack_prev_q;
    logic               vid_cap_q;
    logic [VRAM_DW-1:0] vid_data_q;
    logic [VRAM_DW-1:0] cpu_rdata_q;
    logic               cpu_issue;
    logic               rd_capture;
    logic               ack_fsm;

`ifdef VRAM_POSTED_WRITE_EN
    logic               wbuf_push;
    logic               wbuf_full;
    logic               wbuf_drain;
    logic [VRAM_AW-1:0] wbuf_addr;
    logic [VRAM_DW-1:0] wbuf_data;
    logic               post_ack_q;

    vram_wbuf u_wbuf (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .push        (wbuf_push),
        .push_addr   (cpu_addr),
        .push_data   (cpu_wdata),
        .vid_busy    (vid_rd),
        .full        (wbuf_full),
        .drain       (wbuf_drain),
        .drain_addr  (wbuf_addr),
        .drain_data  (wbuf_data)
    );

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            post_ack_q <= 1'b0;
        end else begin
            post_ack_q <= wbuf_push;
        end
    end

    assign cpu_ack = ack_fsm || (post_ack_q && cpu_req);
`else
    assign cpu_ack = ack_fsm;
`endif

    assign cpu_wait  = cpu_req && !cpu_ack;
    assign vid_data  = vid_data_q;
    assign cpu_rdata = cpu_rdata_q;

    // Arbitration acts on a request that has been held for a full cycle, and never on the
    // cycle right after an ack, when the CPU may still be showing the finished request.
    always_comb begin
        state_d    = state_q;
        cpu_issue  = 1'b0;
        rd_capture = 1'b0;
        ack_fsm    = 1'b0;
`ifdef VRAM_POSTED_WRITE_EN
        wbuf_push  = 1'b0;
`endif
        case (state_q)
            StIdle: begin
`ifdef VRAM_POSTED_WRITE_EN
                if (!wbuf_full && !ack_prev_q) begin
                    if (cpu_req && cpu_we) begin
                        wbuf_push = 1'b1;
                    end else if (req_q && cpu_req && !cpu_we) begin
                        state_d = StIssue;
                    end
                end
`else
                if (req_q && cpu_req && !ack_prev_q) begin
                    state_d = StIssue;
                end
`endif
            end
            StIssue: begin
                if (!cpu_req) begin
                    state_d = StIdle;
                end else if (!vid_rd) begin
                    cpu_issue = 1'b1;
                    state_d   = cpu_we ? StAck : StRdcap;
                end
            end
            StRdcap: begin
                rd_capture = 1'b1;
                state_d    = StAck;
            end
            StAck: begin
                // A request withdrawn mid-access still completes, but is not acknowledged.
                ack_fsm = cpu_req;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_addr  = vid_addr;
        mem_we    = 1'b0;
        mem_wdata = cpu_wdata;
        if (cpu_issue) begin
            mem_addr = cpu_addr;
            mem_we   = cpu_we;
        end
`ifdef VRAM_POSTED_WRITE_EN
        else if (wbuf_drain) begin
            mem_addr  = wbuf_addr;
            mem_we    = 1'b1;
            mem_wdata = wbuf_data;
        end
`endif
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state_q     <= StIdle;
            req_q       <= 1'b0;
            ack_prev_q  <= 1'b0;
            vid_cap_q   <= 1'b0;
            vid_data_q  <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= cpu_req;
            ack_prev_q <= cpu_ack;
            vid_cap_q  <= vid_rd;
            if (vid_cap_q) begin
                vid_data_q <= mem_rdata;
            end
            if (rd_capture) begin
                cpu_rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed, table-driven bench for vram_arbiter with a synchronous RAM model.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vid_rd = 1'b0;
    logic [14:0] vid_addr = '0;
    logic [7:0]  vid_data;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [14:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        cpu_wait;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .pixel_clock (clk),
        .reset       (reset),
        .vid_rd      (vid_rd),
        .vid_addr    (vid_addr),
        .vid_data    (vid_data),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ack     (cpu_ack),
        .cpu_wait    (cpu_wait),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    logic [7:0] ram [0:32767];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic        rst;
        logic        vrd;
        logic [14:0] va;
        logic        req;
        logic        we;
        logic [14:0] ca;
        logic [7:0]  wd;
        logic [14:0] e_addr;
        logic        e_we;
        logic [7:0]  e_wd;
        logic        e_ack;
        logic        e_wait;
        logic        cv;
        logic [7:0]  e_vd;
        logic [7:0]  e_rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic vrd, input logic [14:0] va,
                                input logic req, input logic we, input logic [14:0] ca,
                                input logic [7:0] wd, input logic [14:0] e_addr,
                                input logic e_we, input logic [7:0] e_wd, input logic e_ack,
                                input logic e_wait, input logic cv, input logic [7:0] e_vd,
                                input logic [7:0] e_rd);
        vec_t v;
        v.rst = rst;       v.vrd = vrd;     v.va = va;         v.req = req;
        v.we = we;         v.ca = ca;       v.wd = wd;         v.e_addr = e_addr;
        v.e_we = e_we;     v.e_wd = e_wd;   v.e_ack = e_ack;   v.e_wait = e_wait;
        v.cv = cv;         v.e_vd = e_vd;   v.e_rd = e_rd;
        return v;
    endfunction

    task automatic cmp(input string tag, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        reset     = v.rst;
        vid_rd    = v.vrd;
        vid_addr  = v.va;
        cpu_req   = v.req;
        cpu_we    = v.we;
        cpu_addr  = v.ca;
        cpu_wdata = v.wd;
        @(negedge clk);
        n_vec++;
        cmp(tag, "mem_addr", 32'(mem_addr), 32'(v.e_addr));
        cmp(tag, "mem_we", 32'(mem_we), 32'(v.e_we));
        if (v.e_we) cmp(tag, "mem_wdata", 32'(mem_wdata), 32'(v.e_wd));
        cmp(tag, "cpu_ack", 32'(cpu_ack), 32'(v.e_ack));
        cmp(tag, "cpu_wait", 32'(cpu_wait), 32'(v.e_wait));
        if (v.cv) cmp(tag, "vid_data", 32'(vid_data), 32'(v.e_vd));
        cmp(tag, "cpu_rdata", 32'(cpu_rdata), 32'(v.e_rd));
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) ram[i] <= 8'h00;
        ram[15'h7000] <= 8'hA5;
        ram[15'h7001] <= 8'h5E;
        ram[15'h7010] <= 8'h3C;
        ram[15'h7040] <= 8'h91;
        ram[15'h7041] <= 8'h92;
        ram[15'h7050] <= 8'hEE;

        //            rst vrd va     req we ca      wd     e_addr e_we e_wd a  w  cv vd     rd
        // reset state, then a lone video fetch
        tbl.push_back(mk(1, 0, 15'h1234, 0, 0, 15'h0000, 8'h00, 15'h1234, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00));
        tbl.push_back(mk(0, 1, 15'h7000, 0, 0, 15'h0000, 8'h00, 15'h7000, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00));
        tbl.push_back(mk(0, 0, 15'h0005, 0, 0, 15'h0000, 8'h00, 15'h0005, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00));
        tbl.push_back(mk(0, 0, 15'h0000, 0, 0, 15'h0000, 8'h00, 15'h0000, 0, 8'h00, 0, 0, 1, 8'hA5, 8'h00));
        tbl.push_back(mk(0, 0, 15'h0000, 0, 0, 15'h0000, 8'h00, 15'h0000, 0, 8'h00, 0, 0, 1, 8'hA5, 8'h00));
        // idle CPU read of 0x7010: ack on the fifth cycle of the request
        tbl.push_back(mk(0, 0, 15'h0000, 1, 0, 15'h7010, 8'h00, 15'h0000, 0, 8'h00, 0, 1, 1, 8'hA5, 8'h00));
        tbl.push_back(mk(0, 0, 15'h0000, 1, 0, 15'h7010, 8'h00, 15'h0000, 0, 8'h00, 0, 1, 1, 8'hA5, 8'h00));
        tbl.push_back(mk(0, 0, 15'h0000, 1, 0, 15'h7010, 8'h00, 15'h7010, 0, 8'h00, 0, 1, 1, 8'hA5, 8'h00));
        tbl.push_back(mk(0, 0, 15'h0000, 1, 0, 15'h7010, 8'h00, 15'h0000, 0, 8'h00, 0, 1, 1, 8'hA5, 8'h00));
        tbl.push_back(mk(0, 0, 15'h0000, 1, 0, 15'h7010, 8'h00, 15'h0000, 0, 8'h00, 1, 0, 1, 8'hA5, 8'h3C));
        tbl.push_back(mk(0, 0, 15'h0000, 0, 0, 15'h0000, 8'h00, 15'h0000, 0, 8'h00, 0, 0, 1, 8'hA5, 8'h3C));
`ifndef VRAM_POSTED_WRITE_EN
        // CPU write of 0x5A to 0x7020 against five cycles of video reads
        tbl.push_back(mk(0, 1, 15'h7000, 1, 1, 15'h7020, 8'h5A, 15'h7000, 0, 8'h00, 0, 1, 1, 8'hA5, 8'h3C));
        tbl.push_back(mk(0, 1, 15'h7001, 1, 1, 15'h7020, 8'h5A, 15'h7001, 0, 8'h00, 0, 1, 1, 8'hA5, 8'h3C));
        tbl.push_back(mk(0, 1, 15'h7010, 1, 1, 15'h7020, 8'h5A, 15'h7010, 0, 8'h00, 0, 1, 1, 8'hA5, 8'h3C));
        tbl.push_back(mk(0, 1, 15'h7000, 1, 1, 15'h7020, 8'h5A, 15'h7000, 0, 8'h00, 0, 1, 1, 8'h5E, 8'h3C));
        tbl.push_back(mk(0, 1, 15'h7001, 1, 1, 15'h7020, 8'h5A, 15'h7001, 0, 8'h00, 0, 1, 1, 8'h3C, 8'h3C));
        tbl.push_back(mk(0, 0, 15'h0000, 1, 1, 15'h7020, 8'h5A, 15'h7020, 1, 8'h5A, 0, 1, 1, 8'hA5, 8'h3C));
        tbl.push_back(mk(0, 0, 15'h0000, 1, 1, 15'h7020, 8'h5A, 15'h0000, 0, 8'h00, 1, 0, 1, 8'h5E, 8'h3C));
        tbl.push_back(mk(0, 1, 15'h7020, 0, 0, 15'h0000, 8'h00, 15'h7020, 0, 8'h00, 0, 0, 1, 8'h5E, 8'h3C));
        tbl.push_back(mk(0, 0, 15'h0000, 0, 0, 15'h0000, 8'h00, 15'h0000, 0, 8'h00, 0, 0, 1, 8'h5E, 8'h3C));
        tbl.push_back(mk(0, 0, 15'h0000, 0, 0, 15'h0000, 8'h00, 15'h0000, 0, 8'h00, 0, 0, 1, 8'h5A, 8'h3C));
`endif

        @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // video every other cycle with back-to-back CPU reads of 0x7040 and 0x7041
        apply(mk(0, 1, 15'h7000, 1, 0, 15'h7040, 8'h00, 15'h7000, 0, 8'h00, 0, 1, 0, 8'h00, 8'h3C), "ilv0");
        apply(mk(0, 0, 15'h0000, 1, 0, 15'h7040, 8'h00, 15'h0000, 0, 8'h00, 0, 1, 0, 8'h00, 8'h3C), "ilv1");
        apply(mk(0, 1, 15'h7001, 1, 0, 15'h7040, 8'h00, 15'h7001, 0, 8'h00, 0, 1, 1, 8'hA5, 8'h3C), "ilv2");
        apply(mk(0, 0, 15'h0000, 1, 0, 15'h7040, 8'h00, 15'h7040, 0, 8'h00, 0, 1, 1, 8'hA5, 8'h3C), "ilv3");
        apply(mk(0, 1, 15'h7000, 1, 0, 15'h7040, 8'h00, 15'h7000, 0, 8'h00, 0, 1, 1, 8'h5E, 8'h3C), "ilv4");
        apply(mk(0, 0, 15'h0000, 1, 0, 15'h7040, 8'h00, 15'h0000, 0, 8'h00, 1, 0, 1, 8'h5E, 8'h91), "ilv5");
        apply(mk(0, 1, 15'h7001, 1, 0, 15'h7041, 8'h00, 15'h7001, 0, 8'h00, 0, 1, 1, 8'hA5, 8'h91), "ilv6");
        apply(mk(0, 0, 15'h0000, 1, 0, 15'h7041, 8'h00, 15'h0000, 0, 8'h00, 0, 1, 1, 8'hA5, 8'h91), "ilv7");
        apply(mk(0, 1, 15'h7000, 1, 0, 15'h7041, 8'h00, 15'h7000, 0, 8'h00, 0, 1, 1, 8'h5E, 8'h91), "ilv8");
        apply(mk(0, 0, 15'h0000, 1, 0, 15'h7041, 8'h00, 15'h7041, 0, 8'h00, 0, 1, 1, 8'h5E, 8'h91), "ilv9");
        apply(mk(0, 1, 15'h7001, 1, 0, 15'h7041, 8'h00, 15'h7001, 0, 8'h00, 0, 1, 1, 8'hA5, 8'h91), "ilv10");
        apply(mk(0, 0, 15'h0000, 1, 0, 15'h7041, 8'h00, 15'h0000, 0, 8'h00, 1, 0, 1, 8'hA5, 8'h92), "ilv11");
        apply(mk(0, 0, 15'h0000, 0, 0, 15'h0000, 8'h00, 15'h0000, 0, 8'h00, 0, 0, 1, 8'h5E, 8'h92), "ilv12");

        // reset while the read of 0x7010 sits in the capture state
        apply(mk(0, 0, 15'h0000, 1, 0, 15'h7010, 8'h00, 15'h0000, 0, 8'h00, 0, 1, 1, 8'h5E, 8'h92), "rst0");
        apply(mk(0, 0, 15'h0000, 1, 0, 15'h7010, 8'h00, 15'h0000, 0, 8'h00, 0, 1, 1, 8'h5E, 8'h92), "rst1");
        apply(mk(0, 0, 15'h0000, 1, 0, 15'h7010, 8'h00, 15'h7010, 0, 8'h00, 0, 1, 1, 8'h5E, 8'h92), "rst2");
        apply(mk(1, 0, 15'h0000, 1, 0, 15'h7010, 8'h00, 15'h0000, 0, 8'h00, 0, 1, 1, 8'h5E, 8'h92), "rst3");
        apply(mk(0, 0, 15'h0000, 1, 0, 15'h7010, 8'h00, 15'h0000, 0, 8'h00, 0, 1, 1, 8'h00, 8'h00), "rst4");
        apply(mk(0, 0, 15'h0000, 0, 0, 15'h0000, 8'h00, 15'h0000, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00), "rst5");
        apply(mk(0, 0, 15'h0000, 0, 0, 15'h0000, 8'h00, 15'h0000, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00), "rst6");

`ifndef VRAM_POSTED_WRITE_EN
        // reset while a write of 0x77 to 0x7050 is stalled: RAM must keep 0xEE
        apply(mk(0, 0, 15'h0000, 1, 1, 15'h7050, 8'h77, 15'h0000, 0, 8'h00, 0, 1, 1, 8'h00, 8'h00), "wrs0");
        apply(mk(0, 0, 15'h0000, 1, 1, 15'h7050, 8'h77, 15'h0000, 0, 8'h00, 0, 1, 1, 8'h00, 8'h00), "wrs1");
        apply(mk(1, 1, 15'h7000, 1, 1, 15'h7050, 8'h77, 15'h7000, 0, 8'h00, 0, 1, 1, 8'h00, 8'h00), "wrs2");
        apply(mk(0, 0, 15'h0000, 0, 1, 15'h7050, 8'h77, 15'h0000, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00), "wrs3");
        apply(mk(0, 1, 15'h7050, 0, 0, 15'h0000, 8'h00, 15'h7050, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00), "wrs4");
        apply(mk(0, 0, 15'h0000, 0, 0, 15'h0000, 8'h00, 15'h0000, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00), "wrs5");
        apply(mk(0, 0, 15'h0000, 0, 0, 15'h0000, 8'h00, 15'h0000, 0, 8'h00, 0, 0, 1, 8'hEE, 8'h00), "wrs6");
`else
        // posted write of 0x11 to 0x7030, then a read of it behind three video cycles
        apply(mk(0, 0, 15'h0000, 1, 1, 15'h7030, 8'h11, 15'h0000, 0, 8'h00, 0, 1, 1, 8'h00, 8'h00), "pw0");
        apply(mk(0, 1, 15'h7000, 1, 1, 15'h7030, 8'h11, 15'h7000, 0, 8'h00, 1, 0, 1, 8'h00, 8'h00), "pw1");
        apply(mk(0, 1, 15'h7001, 1, 0, 15'h7030, 8'h00, 15'h7001, 0, 8'h00, 0, 1, 1, 8'h00, 8'h00), "pw2");
        apply(mk(0, 1, 15'h7000, 1, 0, 15'h7030, 8'h00, 15'h7000, 0, 8'h00, 0, 1, 1, 8'hA5, 8'h00), "pw3");
        apply(mk(0, 0, 15'h0000, 1, 0, 15'h7030, 8'h00, 15'h7030, 1, 8'h11, 0, 1, 1, 8'h5E, 8'h00), "pw4");
        apply(mk(0, 0, 15'h0000, 1, 0, 15'h7030, 8'h00, 15'h0000, 0, 8'h00, 0, 1, 1, 8'hA5, 8'h00), "pw5");
        apply(mk(0, 0, 15'h0000, 1, 0, 15'h7030, 8'h00, 15'h7030, 0, 8'h00, 0, 1, 1, 8'hA5, 8'h00), "pw6");
        apply(mk(0, 0, 15'h0000, 1, 0, 15'h7030, 8'h00, 15'h0000, 0, 8'h00, 0, 1, 1, 8'hA5, 8'h00), "pw7");
        apply(mk(0, 0, 15'h0000, 1, 0, 15'h7030, 8'h00, 15'h0000, 0, 8'h00, 1, 0, 1, 8'hA5, 8'h11), "pw8");
        apply(mk(0, 0, 15'h0000, 0, 0, 15'h0000, 8'h00, 15'h0000, 0, 8'h00, 0, 0, 1, 8'hA5, 8'h11), "pw9");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
